// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the fetch and load/store stages
// One transaction in flight; read data is returned to the granted requester.
module mem_port_arbiter #(
    parameter int XLEN             = 32,
    parameter int MEM_READ_LATENCY = 1,
    parameter int DATA_PRIORITY    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_complete,
    output logic [XLEN-1:0] fetch_r_data,
    input  logic            data_req,
    input  logic [XLEN-1:0] data_addr,
    input  logic            data_we,
    input  logic [XLEN-1:0] data_w_data,
    input  logic [3:0]      data_w_mask,
    output logic            data_complete,
    output logic [XLEN-1:0] data_r_data,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_w_en,
    output logic [XLEN-1:0] mem_w_data,
    output logic [3:0]      mem_w_mask,
    input  logic [XLEN-1:0] mem_r_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_READ_LATENCY);

    state_t          state_q, state_d;
    logic            gnt_data_q, gnt_data_d;
    logic            we_q, we_d;
    logic [2:0]      lat_q, lat_d;
    logic            last_data_q, last_data_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_w_en_q, mem_w_en_d;
    logic [XLEN-1:0] mem_w_data_q, mem_w_data_d;
    logic [3:0]      mem_w_mask_q, mem_w_mask_d;
    logic [XLEN-1:0] fetch_r_data_q, fetch_r_data_d;
    logic [XLEN-1:0] data_r_data_q, data_r_data_d;
    logic            pick_data;

    // On a tie without data priority, the requester not served last wins.
    assign pick_data = data_req && (!fetch_req || (DATA_PRIORITY != 0) || !last_data_q);

    always_comb begin
        state_d        = state_q;
        gnt_data_d     = gnt_data_q;
        we_d           = we_q;
        lat_d          = lat_q;
        last_data_d    = last_data_q;
        mem_addr_d     = mem_addr_q;
        mem_w_en_d     = 1'b0;
        mem_w_data_d   = '0;
        mem_w_mask_d   = 4'b0000;
        fetch_r_data_d = fetch_r_data_q;
        data_r_data_d  = data_r_data_q;
        case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    state_d     = ACCESS;
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    lat_d       = 3'd0;
                    if (pick_data) begin
                        mem_addr_d = data_addr;
                        we_d       = data_we;
                        if (data_we) begin
                            mem_w_en_d   = 1'b1;
                            mem_w_data_d = data_w_data;
                            mem_w_mask_d = data_w_mask;
                        end
                    end else begin
                        mem_addr_d = fetch_addr;
                        we_d       = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                    if (gnt_data_q) begin
                        data_r_data_d = mem_r_data;
                    end else begin
                        fetch_r_data_d = mem_r_data;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gnt_data_q     <= 1'b0;
            we_q           <= 1'b0;
            lat_q          <= 3'd0;
            last_data_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_w_en_q     <= 1'b0;
            mem_w_data_q   <= '0;
            mem_w_mask_q   <= 4'b0000;
            fetch_r_data_q <= '0;
            data_r_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            gnt_data_q     <= gnt_data_d;
            we_q           <= we_d;
            lat_q          <= lat_d;
            last_data_q    <= last_data_d;
            mem_addr_q     <= mem_addr_d;
            mem_w_en_q     <= mem_w_en_d;
            mem_w_data_q   <= mem_w_data_d;
            mem_w_mask_q   <= mem_w_mask_d;
            fetch_r_data_q <= fetch_r_data_d;
            data_r_data_q  <= data_r_data_d;
        end
    end

    assign fetch_complete = (state_q == DONE) && !gnt_data_q;
    assign data_complete  = (state_q == DONE) && gnt_data_q;
    assign busy           = (state_q != IDLE);
    assign mem_addr       = mem_addr_q;
    assign mem_w_en       = mem_w_en_q;
    assign mem_w_data     = mem_w_data_q;
    assign mem_w_mask     = mem_w_mask_q;
    assign fetch_r_data   = fetch_r_data_q;
    assign data_r_data    = data_r_data_q;

endmodule
